cluster_fifo_packer: RTL and testbench

- Sits directly downstream of the two-encoder cluster multiplexer.
- On each latch strobe, captures the 8 multiplexed cluster slots, discards invalid slots, and compacts the valid ones in slot order.
- Writes all compacted clusters into a circular buffer in a single cycle.
- The output side is a one-word-per-cycle, first-word-fall-through stream for the link formatter. Overflow is all-or-nothing per event and is counted.

---
 rtl/cluster_fifo_packer.sv | 110 +++++++++++
 tb/tb_cluster_fifo_packer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cluster_fifo_packer.sv
`timescale 1ns/1ps
// Captures 8 cluster slots per latch strobe, compacts valid ones in slot order and
// writes them into a circular buffer in one cycle; FWFT one-word-per-cycle read side.
module cluster_fifo_packer #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clock4x,
   input  logic          global_reset,
   input  logic          latch_in,
   input  logic [111:0]  clusters_in,
   input  logic          rd_en,
   output logic [13:0]   dout,
   output logic          empty,
   output logic [AW:0]   fill,
   output logic          overflow,
   output logic [15:0]   drop_cnt
);
   localparam int NSLOT = 8;

   logic [NSLOT-1:0] slot_vld;
   logic [2:0]       slot_off [NSLOT];
   logic [3:0]       n_vld;
   logic [3:0]       off_acc;

   logic             s1_vld;
   logic [13:0]      s1_slot [NSLOT];
   logic [NSLOT-1:0] s1_mask;
   logic [3:0]       s1_n;
   logic [2:0]       s1_off [NSLOT];

   logic [13:0]      mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic [AW:0]      space;
   logic [AW:0]      wr_n;
   logic             accept;
   logic             pop;

   // Slot k lands at its rank among the valid slots below it.
   always_comb begin
      off_acc = '0;
      for (int k = 0; k < NSLOT; k++) begin
         slot_vld[k] = (clusters_in[14*k+9 +: 2] != 2'b11);
         slot_off[k] = off_acc[2:0];
         off_acc     = off_acc + {3'b000, slot_vld[k]};
      end
      n_vld = off_acc;
   end

   always_ff @(posedge clock4x) begin
      if (global_reset) begin
         s1_vld  <= 1'b0;
         s1_mask <= '0;
         s1_n    <= '0;
         for (int k = 0; k < NSLOT; k++) begin
            s1_slot[k] <= '0;
            s1_off[k]  <= '0;
         end
      end else begin
         s1_vld <= latch_in;
         if (latch_in) begin
            s1_mask <= slot_vld;
            s1_n    <= n_vld;
            for (int k = 0; k < NSLOT; k++) begin
               s1_slot[k] <= clusters_in[14*k +: 14];
               s1_off[k]  <= slot_off[k];
            end
         end
      end
   end

   // Acceptance uses the pre-edge count; a pop in the same cycle earns no credit.
   assign space  = (AW+1)'(DEPTH) - count;
   assign accept = s1_vld && ({{(AW-3){1'b0}}, s1_n} <= space);
   assign wr_n   = accept ? {{(AW-3){1'b0}}, s1_n} : '0;
   assign pop    = rd_en && (count != '0);

   always_ff @(posedge clock4x) begin
      if (global_reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         wr_ptr <= wr_ptr + wr_n[AW-1:0];
         rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, pop};
         count  <= count + wr_n - {{AW{1'b0}}, pop};
         if (s1_vld && !accept) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

   always_ff @(posedge clock4x) begin
      if (accept) begin
         for (int k = 0; k < NSLOT; k++) begin
            if (s1_mask[k]) mem[wr_ptr + AW'(s1_off[k])] <= s1_slot[k];
         end
      end
   end

   assign empty = (count == '0);
   assign fill  = count;
   assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_cluster_fifo_packer.sv
`timescale 1ns/1ps
// Randomised and directed bench for cluster_fifo_packer against a queue-based
// reference model; a negedge monitor compares all outputs every cycle.
module tb_cluster_fifo_packer;
   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic          clock4x = 1'b0;
   logic          global_reset;
   logic          latch_in;
   logic [111:0]  clusters_in;
   logic          rd_en;
   logic [13:0]   dout;
   logic          empty;
   logic [AW:0]   fill;
   logic          overflow;
   logic [15:0]   drop_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   // Reference model: stored words, one pending (captured) event, sticky status.
   logic [13:0] mq[$];
   logic [13:0] pend_q[$];
   bit          pend_v = 1'b0;
   bit          m_ovf = 1'b0;
   int          m_drops = 0;

   always #5 clock4x = ~clock4x;

   cluster_fifo_packer #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clock4x      (clock4x),
      .global_reset (global_reset),
      .latch_in     (latch_in),
      .clusters_in  (clusters_in),
      .rd_en        (rd_en),
      .dout         (dout),
      .empty        (empty),
      .fill         (fill),
      .overflow     (overflow),
      .drop_cnt     (drop_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update for one clock edge, using the inputs the DUT just sampled.
   task automatic model_edge();
      bit do_pop;
      bit acc;
      if (global_reset) begin
         mq.delete(); pend_q.delete(); pend_v = 1'b0; m_ovf = 1'b0; m_drops = 0;
         return;
      end
      do_pop = rd_en && (mq.size() > 0);
      acc = pend_v && (pend_q.size() <= DEPTH - mq.size());
      if (pend_v && !acc) begin
         m_ovf = 1'b1;
         if (m_drops < 65535) m_drops++;
      end
      if (do_pop) void'(mq.pop_front());
      if (acc) foreach (pend_q[i]) mq.push_back(pend_q[i]);
      pend_q.delete();
      pend_v = latch_in;
      if (latch_in) begin
         for (int k = 0; k < 8; k++) begin
            logic [13:0] w;
            w = clusters_in[14*k +: 14];
            if (w[10:0] < 11'd1536) pend_q.push_back(w);
         end
      end
   endtask

   task automatic cyc(input bit l, input logic [111:0] c, input bit r, input bit rst);
      #1;
      latch_in = l; clusters_in = c; rd_en = r; global_reset = rst;
      @(posedge clock4x);
      model_edge();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0);
   endtask

   function automatic logic [111:0] pack8(input logic [10:0] a0, input int step);
      logic [111:0] c;
      c = '0;
      for (int k = 0; k < 8; k++) c[14*k +: 14] = {3'(k), 11'(int'(a0) + step * k)};
      return c;
   endfunction

   function automatic logic [111:0] rand_slots();
      logic [111:0] c;
      for (int k = 0; k < 8; k++) begin
         logic [10:0] a;
         a = ($urandom_range(0, 7) == 0) ? 11'h7FE : 11'($urandom_range(0, 2047));
         c[14*k +: 14] = {3'($urandom_range(0, 7)), a};
      end
      return c;
   endfunction

   always @(negedge clock4x) begin
      if (mon_en) begin
         check("fill", 32'(fill), 32'(mq.size()));
         check("empty", 32'(empty), 32'(mq.size() == 0));
         check("dout", 32'(dout), (mq.size() == 0) ? 32'd0 : 32'(mq[0]));
         check("overflow", 32'(overflow), 32'(m_ovf));
         check("drop_cnt", 32'(drop_cnt), 32'(m_drops));
      end
   end

   initial begin
      logic [111:0] c;
      logic [13:0]  exp1 [5];
      exp1[0] = {3'd0, 11'd5};   exp1[1] = {3'd2, 11'd12}; exp1[2] = {3'd4, 11'd1535};
      exp1[3] = {3'd6, 11'd0};   exp1[4] = {3'd7, 11'd900};

      // Test 1: mixed valid/invalid slots, latency and ordering.
      cyc(1'b0, '0, 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b1);
      mon_en = 1'b1;
      #2;
      check("reset_empty", 32'(empty), 32'd1);
      check("reset_fill", 32'(fill), 32'd0);
      c = '0;
      c[0*14 +: 14] = {3'd0, 11'd5};    c[1*14 +: 14] = {3'd1, 11'h7FE};
      c[2*14 +: 14] = {3'd2, 11'd12};   c[3*14 +: 14] = {3'd3, 11'h600};
      c[4*14 +: 14] = {3'd4, 11'd1535}; c[5*14 +: 14] = {3'd5, 11'h7FF};
      c[6*14 +: 14] = {3'd6, 11'd0};    c[7*14 +: 14] = {3'd7, 11'd900};
      cyc(1'b1, c, 1'b0, 1'b0);
      #2 check("t1_fill_n1", 32'(fill), 32'd0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      #2 check("t1_fill_n2", 32'(fill), 32'd5);
      for (int i = 0; i < 5; i++) begin
         check("t1_pop", 32'(dout), 32'(exp1[i]));
         cyc(1'b0, '0, 1'b1, 1'b0);
         #2;
      end
      check("t1_empty", 32'(empty), 32'd1);

      // Test 2: fill to DEPTH, ninth event dropped.
      cyc(1'b0, '0, 1'b0, 1'b1);
      for (int e = 0; e < 9; e++) begin
         cyc(1'b1, pack8(11'(e * 8), 1), 1'b0, 1'b0);
         idle(3);
      end
      #2;
      check("t2_fill", 32'(fill), 32'd64);
      check("t2_ovf", 32'(overflow), 32'd1);
      check("t2_drops", 32'(drop_cnt), 32'd1);
      check("t2_head", 32'(dout), 32'({3'd0, 11'd0}));

      // Test 3: fill=60, latch 8 with a same-cycle pop; no credit given.
      cyc(1'b0, '0, 1'b0, 1'b1);
      for (int e = 0; e < 7; e++) cyc(1'b1, pack8(11'(e * 8), 1), 1'b0, 1'b0);
      c = pack8(11'd56, 1);
      for (int k = 4; k < 8; k++) c[14*k +: 14] = {3'd0, 11'h7FE};
      cyc(1'b1, c, 1'b0, 1'b0);
      idle(2);
      #2 check("t3_fill60", 32'(fill), 32'd60);
      cyc(1'b1, pack8(11'd300, 1), 1'b1, 1'b0);
      idle(2);
      #2;
      check("t3_fill", 32'(fill), 32'd59);
      check("t3_drops", 32'(drop_cnt), 32'd1);

      // Test 4: drain, then a write straddling the buffer end.
      for (int i = 0; i < 59; i++) cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b1, pack8(11'd100, 1), 1'b0, 1'b0);
      idle(2);
      #2 check("t4_fill", 32'(fill), 32'd8);
      for (int i = 0; i < 8; i++) begin
         check("t4_wrap", 32'(dout[10:0]), 32'(100 + i));
         cyc(1'b0, '0, 1'b1, 1'b0);
         #2;
      end

      // Test 5: reset one cycle after a latch discards the event.
      cyc(1'b1, pack8(11'd200, 1), 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b1);
      idle(3);
      #2;
      check("t5_fill", 32'(fill), 32'd0);
      check("t5_empty", 32'(empty), 32'd1);
      check("t5_ovf", 32'(overflow), 32'd0);
      check("t5_drops", 32'(drop_cnt), 32'd0);
      cyc(1'b1, pack8(11'd400, 2), 1'b0, 1'b0);
      idle(2);
      #2 check("t5_next", 32'(fill), 32'd8);

      // Random phase.
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 3) != 0 ? 1'b0 : 1'b1, rand_slots(),
             1'($urandom_range(0, 1)), ($urandom_range(0, 499) == 0));
      for (int i = 0; i < 2000; i++)
         cyc($urandom_range(0, 1) == 0, rand_slots(), ($urandom_range(0, 3) == 0), 1'b0);

      // Test 6: saturating drop counter.
      cyc(1'b0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 70010; i++) cyc(1'b1, pack8(11'd0, 1), 1'b0, 1'b0);
      idle(2);
      #2;
      check("t6_drops", 32'(drop_cnt), 32'hFFFF);
      check("t6_ovf", 32'(overflow), 32'd1);
      cyc(1'b0, '0, 1'b0, 1'b1);
      #2 check("t6_ovf_clr", 32'(overflow), 32'd0);

      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
